// File: rtl/rvj1_pipe_pkg.sv
// Shared types and defaults for the pipeline valid/ready controller.
package rvj1_pipe_pkg;

  localparam int unsigned DEFAULT_NUM_STAGES = 3;

  // Handshake seen at the input side of a stage: word offered / stage can take it
  typedef struct packed {
    logic valid;
    logic ready;
  } pipe_hs_t;

  // A stage can take a word if it is empty or its word leaves this cycle
  function automatic logic stage_ready(input logic valid, input logic stall,
                                       input logic next_ready);
    return ~valid | (~stall & next_ready);
  endfunction

endpackage

// File: rtl/pipeline_register.sv
// Clock-enabled register with synchronous active-low reset to zero.
module pipeline_register #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      q <= '0;
    end else if (ce) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipeline_stage_ctrl.sv
// Valid bit and load/leave control for a single controlled pipeline stage.
module pipeline_stage_ctrl
  import rvj1_pipe_pkg::*;
(
  input  logic     clk,
  input  logic     rstn,
  input  pipe_hs_t feed,
  input  logic     stall,
  input  logic     kill,
  input  logic     next_ready,
  output logic     ce,
  output logic     valid
);

  logic valid_q;
  logic leave;

  // Load when a word is offered and we can take it; a flush overrides everything
  always_comb begin
    ce    = 1'b0;
    leave = 1'b0;
    ce    = feed.valid & feed.ready & ~kill;
    leave = valid_q & ~stall & next_ready;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q <= 1'b0;
    end else if (kill) begin
      valid_q <= 1'b0;
    end else if (ce) begin
      valid_q <= 1'b1;
    end else if (leave) begin
      valid_q <= 1'b0;
    end
  end

  assign valid = valid_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Valid/ready sequencer for a linear chain of pipeline registers, with flush
// masking and a saturating back-pressure cycle counter.
module pipeline_ctrl
  import rvj1_pipe_pkg::*;
#(
  parameter int unsigned NUM_STAGES   = DEFAULT_NUM_STAGES,
  parameter int unsigned FLUSH_STAGES = 2,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NUM_STAGES-1:0] stall_i,
  input  logic                  flush_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NUM_STAGES-1:0] ce_o,
  output logic [NUM_STAGES-1:0] valid_o,
  output logic [CNT_WIDTH-1:0]  stall_cnt_o
);

  localparam logic FLUSH_ALL = (FLUSH_STAGES >= NUM_STAGES);

  logic [NUM_STAGES-1:0] rdy;
  logic [NUM_STAGES-1:0] next_rdy;
  logic [NUM_STAGES-1:0] src_v;
  logic [NUM_STAGES-1:0] kill;
  logic                  chain;
  logic                  stall_evt;
  logic                  cnt_ce;

  // Ready chain resolved from the output back to stage 0
  always_comb begin
    rdy      = '0;
    next_rdy = '0;
    chain    = out_ready;
    for (int i = int'(NUM_STAGES) - 1; i >= 0; i--) begin
      next_rdy[i] = chain;
      rdy[i]      = stage_ready(valid_o[i], stall_i[i], chain);
      chain       = rdy[i];
    end
  end

  // Word offered to each stage, with the flush boundary masked off
  always_comb begin
    src_v    = '0;
    kill     = '0;
    src_v[0] = in_valid;
    for (int i = 1; i < int'(NUM_STAGES); i++) begin
      src_v[i] = valid_o[i-1] & ~stall_i[i-1];
      if (i == int'(FLUSH_STAGES)) begin
        src_v[i] = src_v[i] & ~flush_i;
      end
    end
    for (int i = 0; i < int'(NUM_STAGES); i++) begin
      kill[i] = flush_i & (i < int'(FLUSH_STAGES));
    end
  end

  for (genvar i = 0; i < int'(NUM_STAGES); i++) begin : g_stage
    pipe_hs_t feed;
    assign feed.valid = src_v[i];
    assign feed.ready = rdy[i];

    pipeline_stage_ctrl u_stage (
      .clk        (clk),
      .rstn       (rstn),
      .feed       (feed),
      .stall      (stall_i[i]),
      .kill       (kill[i]),
      .next_ready (next_rdy[i]),
      .ce         (ce_o[i]),
      .valid      (valid_o[i])
    );
  end

  assign in_ready  = rdy[0] & ~flush_i;
  assign out_valid = valid_o[NUM_STAGES-1] & ~stall_i[NUM_STAGES-1] & ~(flush_i & FLUSH_ALL);

  // Back-pressure counter holds once it reaches all-ones
  assign stall_evt = in_valid & ~in_ready;
  assign cnt_ce    = stall_evt & ~(&stall_cnt_o);

  pipeline_register #(
    .WIDTH (CNT_WIDTH)
  ) u_stall_cnt (
    .clk  (clk),
    .rstn (rstn),
    .ce   (cnt_ce),
    .d    (stall_cnt_o + CNT_WIDTH'(1)),
    .q    (stall_cnt_o)
  );

endmodule
